// File: rtl/riu_pkg.sv
// Shared constants and types for the RIU integer-core control path.
package riu_pkg;

    // Major opcodes handled by the core
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // Control FSM states
    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        DECODE,
        EXEC,
        WB,
        TRAP
    } state_t;

    // ALU operation: {sub_sra, funct3}
    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SUB  = 4'b1000;
    localparam alu_op_t ALU_SLL  = 4'b0001;
    localparam alu_op_t ALU_SLT  = 4'b0010;
    localparam alu_op_t ALU_SLTU = 4'b0011;
    localparam alu_op_t ALU_XOR  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_SRA  = 4'b1101;
    localparam alu_op_t ALU_OR   = 4'b0110;
    localparam alu_op_t ALU_AND  = 4'b0111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/riu_ctrl_classify.sv
// Combinational instruction classifier: legality check plus ALU/operand/write-back controls.
module riu_ctrl_classify
    import riu_pkg::*;
(
    input  logic [31:0] instr,
    output logic        legal,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic        wb_sel
);

    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    // Register indices and immediate low bits play no part in classification
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    // Decode opcode and funct fields into control outputs and a legality flag
    always_comb begin
        legal       = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        wb_sel      = 1'b0;
        case (instr[6:0])
            OP_RTYPE: begin
                alu_op = {instr[30], funct3};
                legal  = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OP_ITYPE: begin
                alu_src_imm = 1'b1;
                // Only shift-right uses bit 30 to pick arithmetic vs logical
                alu_op      = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
                case (funct3)
                    3'b001:  legal = (funct7 == 7'b0000000);
                    3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
            end
            OP_LUI: begin
                legal  = 1'b1;
                wb_sel = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/riu_ctrl.sv
// Multicycle control FSM: fetch, decode, execute and write back one instruction at a time.
module riu_ctrl
    import riu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic        wb_sel,
    output logic        rf_we,
    output logic        retire,
    output logic        illegal
);

    state_t     state;
    logic       cls_legal;
    logic [3:0] cls_alu_op;
    logic       cls_alu_src_imm;
    logic       cls_wb_sel;

    riu_ctrl_classify u_classify (
        .instr       (instr),
        .legal       (cls_legal),
        .alu_op      (cls_alu_op),
        .alu_src_imm (cls_alu_src_imm),
        .wb_sel      (cls_wb_sel)
    );

    // Request is combinational so a grant can be taken in the first FETCH cycle
    assign imem_req  = (state == FETCH) && !stall;
    assign imem_addr = pc;

    // Control FSM with registered control outputs and strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= NOP;
            alu_op      <= ALU_ADD;
            alu_src_imm <= 1'b0;
            wb_sel      <= 1'b0;
            rf_we       <= 1'b0;
            retire      <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            rf_we  <= 1'b0;
            retire <= 1'b0;
            case (state)
                FETCH: begin
                    if (imem_req && imem_gnt) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr <= imem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (cls_legal) begin
                        alu_op      <= cls_alu_op;
                        alu_src_imm <= cls_alu_src_imm;
                        wb_sel      <= cls_wb_sel;
                        state       <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= TRAP;
                    end
                end
                EXEC: begin
                    // Strobes are registered so they are high for exactly the WB cycle
                    rf_we  <= 1'b1;
                    retire <= 1'b1;
                    state  <= WB;
                end
                WB: begin
                    pc    <= pc + PC_STEP;
                    state <= FETCH;
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riu_ctrl.sv
// Self-checking bench for riu_ctrl: vector table plus multi-cycle handshake/trap/reset sequences.
module tb_riu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        wb_sel;
    logic        rf_we;
    logic        retire;
    logic        illegal;

    int total = 0;
    int bad = 0;

    // Memory model knobs
    logic        gnt_ok = 1'b1;
    int          rv_delay = 0;
    logic [31:0] mem_word = 32'h0000_0013;
    logic        pend = 1'b0;
    int          rv_cnt = 0;

    always #5 clk = ~clk;

    riu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .instr       (instr),
        .pc          (pc),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .wb_sel      (wb_sel),
        .rf_we       (rf_we),
        .retire      (retire),
        .illegal     (illegal)
    );

    assign imem_gnt = imem_req & gnt_ok;

    // Memory: answers rv_delay cycles after the grant cycle, drops pending responses on reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= 1'b0;
            imem_rvalid <= 1'b0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_req && imem_gnt) begin
                if (rv_delay == 0) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word;
                end else begin
                    pend   <= 1'b1;
                    rv_cnt <= rv_delay - 1;
                end
            end else if (pend) begin
                if (rv_cnt == 0) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word;
                    pend        <= 1'b0;
                end else begin
                    rv_cnt <= rv_cnt - 1;
                end
            end
        end
    end

    typedef struct packed {
        logic [31:0] ins;
        logic        legal;
        logic [3:0]  op;
        logic        src;
        logic        wb;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reset, then release mid-cycle; the cycle in progress after release is cycle 1
    task automatic do_reset(input logic [31:0] word, input int delay, input logic gok);
        rst_n    = 1'b0;
        stall    = 1'b0;
        gnt_ok   = gok;
        rv_delay = delay;
        mem_word = word;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Step until retire or illegal is seen; cyc is the cycle number it was seen in
    task automatic run_until(output int cyc, input int limit);
        cyc = 1;
        while (!retire && !illegal && cyc < limit) begin
            tick();
            cyc++;
        end
        if (!retire && !illegal) begin
            check("run_timeout", 32'(cyc), 32'(limit + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic req_seen;
        logic we_seen;
        logic addr_bad;

        vecs[0]  = '{32'h00208033, 1'b1, 4'b0000, 1'b0, 1'b0}; // add
        vecs[1]  = '{32'h40315093, 1'b1, 4'b1101, 1'b1, 1'b0}; // srai
        vecs[2]  = '{32'h123450B7, 1'b1, 4'b0000, 1'b0, 1'b1}; // lui
        vecs[3]  = '{32'h02208033, 1'b0, 4'b0000, 1'b0, 1'b0}; // funct7=0000001
        vecs[4]  = '{32'h00000073, 1'b0, 4'b0000, 1'b0, 1'b0}; // ecall
        vecs[5]  = '{32'h40208033, 1'b1, 4'b1000, 1'b0, 1'b0}; // sub
        vecs[6]  = '{32'h40209033, 1'b0, 4'b0000, 1'b0, 1'b0}; // sll with funct7=0100000
        vecs[7]  = '{32'h00209093, 1'b1, 4'b0001, 1'b1, 1'b0}; // slli
        vecs[8]  = '{32'h40209093, 1'b0, 4'b0000, 1'b0, 1'b0}; // slli bad funct7
        vecs[9]  = '{32'hFFF08093, 1'b1, 4'b0000, 1'b1, 1'b0}; // addi -1, bit30 ignored
        vecs[10] = '{32'h0020D093, 1'b1, 4'b0101, 1'b1, 1'b0}; // srli
        vecs[11] = '{32'h6020D093, 1'b0, 4'b0000, 1'b0, 1'b0}; // shift-right bad funct7
        vecs[12] = '{32'h4020C033, 1'b0, 4'b0000, 1'b0, 1'b0}; // xor with funct7=0100000
        vecs[13] = '{32'h0020F033, 1'b1, 4'b0111, 1'b0, 1'b0}; // and
        vecs[14] = '{32'h4020D033, 1'b1, 4'b1101, 1'b0, 1'b0}; // sra
        vecs[15] = '{32'h40002013, 1'b1, 4'b0010, 1'b1, 1'b0}; // slti, bit30 ignored

        // Reset state while held in reset
        rst_n = 1'b0;
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_ctrl", {28'h0, alu_op}, 32'h0);
        check("rst_strobes", {28'h0, rf_we, retire, illegal, wb_sel}, 32'h0);

        // Table of single instructions with zero-wait memory
        for (int i = 0; i < NV; i++) begin
            do_reset(vecs[i].ins, 0, 1'b1);
            check("fetch_addr", imem_addr, 32'h0);
            run_until(cyc, 30);
            if (vecs[i].legal) begin
                check("retire_cycle", 32'(cyc), 32'd5);
                check("retire", {31'h0, retire}, 32'h1);
                check("rf_we", {31'h0, rf_we}, 32'h1);
                check("alu_op", {28'h0, alu_op}, {28'h0, vecs[i].op});
                check("alu_src_imm", {31'h0, alu_src_imm}, {31'h0, vecs[i].src});
                check("wb_sel", {31'h0, wb_sel}, {31'h0, vecs[i].wb});
                check("instr", instr, vecs[i].ins);
                tick();
                check("pc_next", pc, 32'h4);
                check("rf_we_off", {31'h0, rf_we}, 32'h0);
            end else begin
                check("trap_cycle", 32'(cyc), 32'd4);
                check("illegal", {31'h0, illegal}, 32'h1);
                check("trap_rf_we", {31'h0, rf_we}, 32'h0);
                check("trap_pc", pc, 32'h0);
            end
        end

        // srai with response 3 cycles late
        do_reset(32'h40315093, 3, 1'b1);
        run_until(cyc, 30);
        check("slow_retire_cycle", 32'(cyc), 32'd8);
        check("slow_alu_op", {28'h0, alu_op}, 32'hD);
        check("slow_src", {31'h0, alu_src_imm}, 32'h1);
        check("slow_rf_we", {31'h0, rf_we}, 32'h1);
        tick();
        check("slow_rf_we_once", {31'h0, rf_we}, 32'h0);
        check("slow_pc", pc, 32'h4);

        // ecall traps and stays quiet
        do_reset(32'h00000073, 0, 1'b1);
        run_until(cyc, 30);
        check("ecall_illegal", {31'h0, illegal}, 32'h1);
        req_seen = 1'b0;
        we_seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            req_seen |= imem_req;
            we_seen  |= rf_we | retire;
        end
        check("trap_req_quiet", {31'h0, req_seen}, 32'h0);
        check("trap_we_quiet", {31'h0, we_seen}, 32'h0);
        check("trap_pc_frozen", pc, 32'h0);
        check("trap_sticky", {31'h0, illegal}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("trap_reset_clears", {31'h0, illegal}, 32'h0);

        // Grant held off 4 cycles, then stall after a retire
        do_reset(32'h00208033, 0, 1'b0);
        addr_bad = 1'b0;
        req_seen = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_seen &= imem_req;
            addr_bad |= (imem_addr != 32'h0);
            if (k < 3) tick();
        end
        check("gnt_wait_req", {31'h0, req_seen}, 32'h1);
        check("gnt_wait_addr", {31'h0, addr_bad}, 32'h0);
        gnt_ok = 1'b1;
        run_until(cyc, 30);
        check("gnt_wait_retire_cycle", 32'(cyc), 32'd5);
        stall    = 1'b1;
        mem_word = 32'h123450B7;
        req_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            req_seen |= imem_req;
        end
        check("stall_req_low", {31'h0, req_seen}, 32'h0);
        check("stall_pc", pc, 32'h4);
        stall = 1'b0;
        #1;
        check("resume_req", {31'h0, imem_req}, 32'h1);
        check("resume_addr", imem_addr, 32'h4);
        run_until(cyc, 30);
        check("resume_retire_cycle", 32'(cyc), 32'd5);
        check("resume_wb_sel", {31'h0, wb_sel}, 32'h1);
        tick();
        check("resume_pc", pc, 32'h8);

        // Reset during WAIT with pc=0x10
        do_reset(32'h00108093, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            run_until(cyc, 30);
            tick();
        end
        check("pc_before_rst", pc, 32'h10);
        rv_delay = 10;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_illegal", {31'h0, illegal}, 32'h0);
        tick();
        rv_delay = 0;
        mem_word = 32'h0020F033;
        rst_n = 1'b1;
        #1;
        check("midrst_req", {31'h0, imem_req}, 32'h1);
        check("midrst_addr", imem_addr, 32'h0);
        run_until(cyc, 30);
        check("midrst_retire_cycle", 32'(cyc), 32'd5);
        check("midrst_alu_op", {28'h0, alu_op}, 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
